// File: rtl/vip_rgb888_to_raw_if.sv
// Stream bundle for the RGB888-to-RAW re-mosaic stage: RGB input side,
// RAW output side and the frame geometry status flags.
interface vip_rgb888_to_raw_if #(
    parameter int DATA_W = 8
);
    logic              pre_frame_vsync;
    logic              pre_frame_href;
    logic [DATA_W-1:0] pre_img_red;
    logic [DATA_W-1:0] pre_img_green;
    logic [DATA_W-1:0] pre_img_blue;
    logic              post_frame_vsync;
    logic              post_frame_href;
    logic [DATA_W-1:0] post_img_RAW;
    logic              line_len_err;
    logic              frame_len_err;
    logic              frame_done;

    // Source side: drives the RGB stream, observes the RAW stream and status
    modport master (
        output pre_frame_vsync, pre_frame_href,
        output pre_img_red, pre_img_green, pre_img_blue,
        input  post_frame_vsync, post_frame_href, post_img_RAW,
        input  line_len_err, frame_len_err, frame_done
    );

    // Block side: consumes the RGB stream, produces the RAW stream and status
    modport slave (
        input  pre_frame_vsync, pre_frame_href,
        input  pre_img_red, pre_img_green, pre_img_blue,
        output post_frame_vsync, post_frame_href, post_img_RAW,
        output line_len_err, frame_len_err, frame_done
    );
endinterface

// File: rtl/vip_rgb888_to_raw.sv
// Bayer re-mosaic: picks one colour channel per pixel according to the
// configured CFA order, delays the framing by one clock and checks the
// frame geometry against the expected resolution.
module vip_rgb888_to_raw #(
    parameter logic [1:0]  BAYER_PATTERN = 2'b00,
    parameter logic [12:0] IMG_HDISP     = 13'd640,
    parameter logic [12:0] IMG_VDISP     = 13'd480,
    parameter logic [4:0]  DATA_W        = 5'd8
) (
    input  logic                clk,
    input  logic                rst_n,
    vip_rgb888_to_raw_if.slave  bus
);
    localparam logic [13:0] CNT_MAX = 14'h3FFF;
    localparam logic [13:0] HDISP   = {1'b0, IMG_HDISP};
    localparam logic [13:0] VDISP   = {1'b0, IMG_VDISP};

    logic              vsync;
    logic              href;
    logic              vsync_r;
    logic              href_r;
    logic              href_fall;
    logic              vsync_fall;
    logic              vsync_rise;
    logic [13:0]       point_cnt;
    logic [13:0]       line_cnt;
    logic [13:0]       lines_at_end;
    logic [1:0]        phase;
    logic [DATA_W-1:0] sel_sample;
    logic [DATA_W-1:0] raw_r;
    logic              line_err_r;
    logic              frame_err_r;
    logic              done_r;

    assign vsync = bus.pre_frame_vsync;
    assign href  = bus.pre_frame_href;
    assign phase = {line_cnt[0], point_cnt[0]};

    // Edge detects against the registered framing, plus the line total the
    // frame compare should see when the last line ends on the vsync edge
    always_comb begin
        href_fall    = href_r & ~href;
        vsync_fall   = vsync_r & ~vsync;
        vsync_rise   = ~vsync_r & vsync;
        lines_at_end = line_cnt;
        if (href_fall && (line_cnt != CNT_MAX)) begin
            lines_at_end = line_cnt + 14'd1;
        end
    end

    // Channel select from the CFA order and the pixel/line parity
    always_comb begin
        sel_sample = '0;
        case ({BAYER_PATTERN, phase})
            4'b00_00: sel_sample = bus.pre_img_red;
            4'b00_01: sel_sample = bus.pre_img_green;
            4'b00_10: sel_sample = bus.pre_img_green;
            4'b00_11: sel_sample = bus.pre_img_blue;
            4'b01_00: sel_sample = bus.pre_img_green;
            4'b01_01: sel_sample = bus.pre_img_red;
            4'b01_10: sel_sample = bus.pre_img_blue;
            4'b01_11: sel_sample = bus.pre_img_green;
            4'b10_00: sel_sample = bus.pre_img_green;
            4'b10_01: sel_sample = bus.pre_img_blue;
            4'b10_10: sel_sample = bus.pre_img_red;
            4'b10_11: sel_sample = bus.pre_img_green;
            4'b11_00: sel_sample = bus.pre_img_blue;
            4'b11_01: sel_sample = bus.pre_img_green;
            4'b11_10: sel_sample = bus.pre_img_green;
            4'b11_11: sel_sample = bus.pre_img_red;
            default:  sel_sample = '0;
        endcase
    end

    // One-clock output pipeline; the framing copies double as edge history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_r <= 1'b0;
            href_r  <= 1'b0;
            raw_r   <= '0;
        end else begin
            vsync_r <= vsync;
            href_r  <= href;
            raw_r   <= href ? sel_sample : '0;
        end
    end

    // Saturating pixel and line position counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            point_cnt <= '0;
            line_cnt  <= '0;
        end else begin
            if (!href) begin
                point_cnt <= '0;
            end else if (point_cnt != CNT_MAX) begin
                point_cnt <= point_cnt + 14'd1;
            end
            if (!vsync) begin
                line_cnt <= '0;
            end else if (href_fall && (line_cnt != CNT_MAX)) begin
                line_cnt <= line_cnt + 14'd1;
            end
        end
    end

    // Geometry checks: sticky per-frame line error, per-frame line total
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_err_r  <= 1'b0;
            frame_err_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= vsync_fall;
            if (vsync_fall) begin
                frame_err_r <= (lines_at_end != VDISP);
            end
            if (href_fall && (point_cnt != HDISP)) begin
                line_err_r <= 1'b1;
            end else if (vsync_rise) begin
                line_err_r <= 1'b0;
            end
        end
    end

    assign bus.post_frame_vsync = vsync_r;
    assign bus.post_frame_href  = href_r;
    assign bus.post_img_RAW     = raw_r;
    assign bus.line_len_err     = line_err_r;
    assign bus.frame_len_err    = frame_err_r;
    assign bus.frame_done       = done_r;
endmodule
